motion_sched: RTL and testbench
===============================

MOTION_SCHED -- requirements
Module: motion_sched

Interface
REQ-001 Parameter H, default 1280, visible width in pixels.
REQ-002 Parameter V, default 1024, visible height in pixels.
REQ-003 Parameter LARGHEZZA, default 400, frame width; parameter ALTEZZA, default 300, frame height.
REQ-004 Parameter STEP, default 1, pixels moved per frame tick; 1 <= STEP < min(H-LARGHEZZA, V-ALTEZZA).
REQ-005 Parameter IDLE_FRAMES, default 120, idle ticks before autonomous motion; range 1..255.
REQ-006 VGA_CLK  in  1  pixel clock; sole clock; all state on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 VGA_VS  in  1  vertical sync; asynchronous to logic, synchronized internally.
REQ-009 btn_x_n, btn_y_n  in  1 each  active-low move requests for X and Y axes; asynchronous.
REQ-010 dir_x, dir_y  in  1 each  manual direction; 1 = increasing coordinate.
REQ-011 auto_en  in  1  enables autonomous bounce mode.
REQ-012 posx, posy  out  11 each  top-left corner of frame, registered.
REQ-013 frame_tick  out  1  one-cycle pulse marking a position update slot.
REQ-014 mode  out  2  00 IDLE, 01 MANUAL, 10 AUTO; 11 never driven.

Function
REQ-015 VGA_VS, btn_x_n, and btn_y_n shall each pass through a 2-flop synchronizer before use.
REQ-016 Tick = synchronized VGA_VS 0->1 transition; frame_tick shall assert exactly one cycle, 3 VGA_CLK edges after the first edge sampling VGA_VS high.
REQ-017 posx, posy, mode, and direction registers shall change only on the edge where frame_tick asserts; they hold otherwise.
REQ-018 XMAX = H-LARGHEZZA (880), YMAX = V-ALTEZZA (724); posx in [0,XMAX] and posy in [0,YMAX] at all times.
REQ-019 Manual step, per pressed axis: increasing -> min(pos+STEP, MAX); decreasing -> pos-STEP, or 0 if pos < STEP; no wrap-around.
REQ-020 A manual X step shall load vx <= dir_x; a manual Y step shall load vy <= dir_y.
REQ-021 Auto step, per axis with velocity bit v: if v=1 and pos+STEP >= MAX, then pos <= MAX and v <= 0; if v=0 and pos <= STEP, then pos <= 0 and v <= 1; otherwise pos <= pos +/- STEP.
REQ-022 idle_cnt: 8-bit, saturating; increments on each tick in IDLE, cleared on any exit from IDLE and on entry to IDLE.
REQ-023 IDLE on tick: any button pressed -> MANUAL, with manual step applied the same tick.
REQ-024 IDLE on tick, no button pressed: if auto_en=1 and idle_cnt == IDLE_FRAMES-1 -> AUTO, no step; otherwise stay IDLE, no step.
REQ-025 MANUAL on tick: any button pressed -> stay MANUAL and apply manual step; none pressed -> IDLE, no step.
REQ-026 AUTO on tick: any button pressed -> MANUAL with manual step (manual has priority).
REQ-027 AUTO on tick, no button pressed: auto_en=0 -> IDLE, positions held; otherwise apply auto step to both axes.
REQ-028 Both buttons pressed shall step both axes in the same tick.
REQ-029 Changes of auto_en or dir_* between ticks shall have no effect until the next tick.

Reset
REQ-030 On reset assertion, immediately and asynchronously:
- posx = 440, posy = 362 ((H-LARGHEZZA)/2, (V-ALTEZZA)/2)
- mode = IDLE, idle_cnt = 0, vx = vy = 1
- frame_tick = 0, all synchronizer flops = 0
REQ-031 Reset shall override a coincident tick.
REQ-032 A VGA_VS already high at reset release shall not produce a tick until it goes low then high again.

Verification
REQ-033 Hold btn_x_n=0, dir_x=1 from reset for 3 ticks -> posx 441, 442, 443; mode=01; posy stays 362.
REQ-034 posx=879, MANUAL increasing, 2 ticks -> posx 880, 880; then dir_x=0 at posx=0 -> posx stays 0.
REQ-035 auto_en=1, no buttons, IDLE_FRAMES=4 -> ticks 1-3 IDLE, tick 4 enters AUTO with position unchanged, tick 5 -> posx 441 and posy 363.
REQ-036 AUTO with posx=879, vx=1 -> next tick posx=880 and vx=0; the following tick posx=879.
REQ-037 In AUTO, press btn_y_n with dir_y=0 -> same tick mode=01, posy decrements, posx unchanged; after release -> IDLE, idle_cnt=0.
REQ-038 Assert reset mid-frame in AUTO -> outputs take reset values without a clock edge; frame_tick=0 throughout.

Source files
------------

// File: rtl/motion_sched.sv
// Moves a LARGHEZZA x ALTEZZA frame around an H x V screen, one update slot per vertical sync.
// Latency: frame_tick and the position update land 3 edges after VGA_VS is first sampled high; no backpressure.
module motion_sched #(
    parameter int H           = 1280,
    parameter int V           = 1024,
    parameter int LARGHEZZA   = 400,
    parameter int ALTEZZA     = 300,
    parameter int STEP        = 1,
    parameter int IDLE_FRAMES = 120
) (
    input  logic        VGA_CLK,
    input  logic        reset,
    input  logic        VGA_VS,
    input  logic        btn_x_n,
    input  logic        btn_y_n,
    input  logic        dir_x,
    input  logic        dir_y,
    input  logic        auto_en,
    output logic [10:0] posx,
    output logic [10:0] posy,
    output logic        frame_tick,
    output logic [1:0]  mode
);

    localparam logic [10:0] XMAX     = 11'(H - LARGHEZZA);
    localparam logic [10:0] YMAX     = 11'(V - ALTEZZA);
    localparam logic [10:0] X_HOME   = 11'((H - LARGHEZZA) / 2);
    localparam logic [10:0] Y_HOME   = 11'((V - ALTEZZA) / 2);
    localparam logic [10:0] STEP_W   = 11'(STEP);
    localparam logic [7:0]  IDLE_CMP = 8'(IDLE_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MANUAL = 2'b01,
        AUTO   = 2'b10
    } mode_e;

    logic [1:0]  vs_sync_q, bx_sync_q, by_sync_q;
    logic        vs_prev_q;
    logic [1:0]  warm_q;
    logic        armed_q;
    logic        tick_q;
    logic [10:0] posx_q, posx_d, posy_q, posy_d;
    logic        vx_q, vx_d, vy_q, vy_d;
    mode_e       mode_q, mode_d;
    logic [7:0]  idle_cnt_q, idle_cnt_d;

    logic        tick, bx_press, by_press, btn_any, do_manual;
    logic [11:0] auto_x, auto_y;

    function automatic logic [10:0] man_step(input logic [10:0] pos, input logic inc,
                                             input logic [10:0] pmax);
        logic [11:0] sum;
        sum = {1'b0, pos} + {1'b0, STEP_W};
        if (inc)
            man_step = (sum >= {1'b0, pmax}) ? pmax : sum[10:0];
        else
            man_step = (pos < STEP_W) ? 11'd0 : pos - STEP_W;
    endfunction

    // Returns {new velocity, new position}; bounces off 0 and pmax.
    function automatic logic [11:0] auto_step(input logic [10:0] pos, input logic v,
                                              input logic [10:0] pmax);
        logic [11:0] sum;
        sum = {1'b0, pos} + {1'b0, STEP_W};
        if (v)
            auto_step = (sum >= {1'b0, pmax}) ? {1'b0, pmax} : {1'b1, sum[10:0]};
        else
            auto_step = (pos <= STEP_W) ? {1'b1, 11'd0} : {1'b0, pos - STEP_W};
    endfunction

    // armed_q only sets once the synchronizer holds real samples and VS is seen low,
    // so a VS already high at reset release cannot look like a rising edge.
    assign tick     = vs_sync_q[1] & ~vs_prev_q & armed_q;
    assign bx_press = ~bx_sync_q[1];
    assign by_press = ~by_sync_q[1];
    assign btn_any  = bx_press | by_press;
    assign auto_x   = auto_step(posx_q, vx_q, XMAX);
    assign auto_y   = auto_step(posy_q, vy_q, YMAX);

    always_comb begin
        posx_d     = posx_q;
        posy_d     = posy_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        mode_d     = mode_q;
        idle_cnt_d = idle_cnt_q;
        do_manual  = 1'b0;
        if (tick) begin
            case (mode_q)
                IDLE: begin
                    if (btn_any) begin
                        mode_d     = MANUAL;
                        idle_cnt_d = 8'd0;
                        do_manual  = 1'b1;
                    end else if (auto_en && idle_cnt_q == IDLE_CMP) begin
                        mode_d     = AUTO;
                        idle_cnt_d = 8'd0;
                    end else if (idle_cnt_q != 8'hFF) begin
                        idle_cnt_d = idle_cnt_q + 8'd1;
                    end
                end
                MANUAL: begin
                    if (btn_any) begin
                        do_manual = 1'b1;
                    end else begin
                        mode_d     = IDLE;
                        idle_cnt_d = 8'd0;
                    end
                end
                AUTO: begin
                    if (btn_any) begin
                        mode_d    = MANUAL;
                        do_manual = 1'b1;
                    end else if (!auto_en) begin
                        mode_d     = IDLE;
                        idle_cnt_d = 8'd0;
                    end else begin
                        {vx_d, posx_d} = auto_x;
                        {vy_d, posy_d} = auto_y;
                    end
                end
                default: begin
                    mode_d     = IDLE;
                    idle_cnt_d = 8'd0;
                end
            endcase
            if (do_manual && bx_press) begin
                posx_d = man_step(posx_q, dir_x, XMAX);
                vx_d   = dir_x;
            end
            if (do_manual && by_press) begin
                posy_d = man_step(posy_q, dir_y, YMAX);
                vy_d   = dir_y;
            end
        end
    end

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            vs_sync_q  <= 2'b00;
            bx_sync_q  <= 2'b00;
            by_sync_q  <= 2'b00;
            vs_prev_q  <= 1'b0;
            warm_q     <= 2'b00;
            armed_q    <= 1'b0;
            tick_q     <= 1'b0;
            posx_q     <= X_HOME;
            posy_q     <= Y_HOME;
            vx_q       <= 1'b1;
            vy_q       <= 1'b1;
            mode_q     <= IDLE;
            idle_cnt_q <= 8'd0;
        end else begin
            vs_sync_q  <= {vs_sync_q[0], VGA_VS};
            bx_sync_q  <= {bx_sync_q[0], btn_x_n};
            by_sync_q  <= {by_sync_q[0], btn_y_n};
            vs_prev_q  <= vs_sync_q[1];
            warm_q     <= {warm_q[0], 1'b1};
            armed_q    <= armed_q | (warm_q[1] & ~vs_sync_q[1]);
            tick_q     <= tick;
            posx_q     <= posx_d;
            posy_q     <= posy_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            mode_q     <= mode_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign posx       = posx_q;
    assign posy       = posy_q;
    assign frame_tick = tick_q;
    assign mode       = mode_q;

endmodule

// File: tb/tb_motion_sched.sv
// Bench for motion_sched: ticks are issued with their expected {posx,posy,mode} queued;
// a monitor pops and compares each time frame_tick is seen.
module tb_motion_sched;

    logic        VGA_CLK = 1'b0;
    logic        reset = 1'b0;
    logic        VGA_VS, btn_x_n, btn_y_n, dir_x, dir_y, auto_en;
    logic [10:0] posx, posy;
    logic        frame_tick;
    logic [1:0]  mode;

    int          checks = 0;
    int          errors = 0;
    int          tick_no = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_e;

    motion_sched #(.IDLE_FRAMES(4)) dut (
        .VGA_CLK(VGA_CLK), .reset(reset), .VGA_VS(VGA_VS),
        .btn_x_n(btn_x_n), .btn_y_n(btn_y_n), .dir_x(dir_x), .dir_y(dir_y),
        .auto_en(auto_en), .posx(posx), .posy(posy),
        .frame_tick(frame_tick), .mode(mode)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every frame_tick cycle must match the next queued expectation.
    always @(negedge VGA_CLK) begin
        if (frame_tick) begin
            tick_no++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick #%0d actual=posx %0d posy %0d mode %0d required=no tick",
                         tick_no, posx, posy, mode);
            end else begin
                mon_e = exp_q.pop_front();
                chk($sformatf("tick%0d_posx", tick_no), int'(posx), int'(mon_e[23:13]));
                chk($sformatf("tick%0d_posy", tick_no), int'(posy), int'(mon_e[12:2]));
                chk($sformatf("tick%0d_mode", tick_no), int'(mode), int'(mon_e[1:0]));
            end
        end
    end

    task automatic push(input int ex, input int ey, input int em);
        exp_q.push_back({11'(ex), 11'(ey), 2'(em)});
    endtask

    // One VS pulse; outputs must still hold the expected values once VS is back low.
    task automatic tick(input int ex, input int ey, input int em);
        push(ex, ey, em);
        @(negedge VGA_CLK) VGA_VS = 1'b1;
        repeat (4) @(negedge VGA_CLK);
        VGA_VS = 1'b0;
        repeat (4) @(negedge VGA_CLK);
        chk("hold_posx", int'(posx), ex);
        chk("hold_posy", int'(posy), ey);
        chk("hold_mode", int'(mode), em);
    endtask

    // Autonomous bounce from (440,362) with both velocities increasing, after k steps.
    function automatic int px(input int k);
        px = (k <= 440) ? 440 + k : 880 - (k - 440);
    endfunction
    function automatic int py(input int k);
        py = (k <= 362) ? 362 + k : 724 - (k - 362);
    endfunction

    initial begin
        VGA_VS = 1'b0; btn_x_n = 1'b0; btn_y_n = 1'b1;
        dir_x = 1'b1; dir_y = 1'b1; auto_en = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_posx", int'(posx), 440);
        chk("rst_posy", int'(posy), 362);
        chk("rst_mode", int'(mode), 0);
        chk("rst_frame_tick", int'(frame_tick), 0);
        repeat (3) @(negedge VGA_CLK);
        reset = 1'b0;
        repeat (4) @(negedge VGA_CLK);

        // First tick: measure frame_tick placement edge by edge.
        push(441, 362, 1);
        @(negedge VGA_CLK) VGA_VS = 1'b1;
        @(negedge VGA_CLK) chk("lat_edge1", int'(frame_tick), 0);
        @(negedge VGA_CLK) chk("lat_edge2", int'(frame_tick), 0);
        @(negedge VGA_CLK) chk("lat_edge3", int'(frame_tick), 1);
        @(negedge VGA_CLK) chk("lat_edge4", int'(frame_tick), 0);
        chk("lat_posx_held", int'(posx), 441);
        VGA_VS = 1'b0;
        repeat (4) @(negedge VGA_CLK);

        // Manual +X up to and pinned at XMAX.
        for (int i = 2; i <= 441; i++)
            tick((440 + i > 880) ? 880 : 440 + i, 362, 1);
        // Manual -X down to and pinned at 0.
        dir_x = 1'b0;
        for (int i = 1; i <= 882; i++)
            tick((880 - i < 0) ? 0 : 880 - i, 362, 1);

        // Fresh reset, then idle countdown into AUTO and a full bounce.
        @(negedge VGA_CLK) reset = 1'b1;
        btn_x_n = 1'b1; auto_en = 1'b1;
        @(negedge VGA_CLK) reset = 1'b0;
        repeat (4) @(negedge VGA_CLK);
        for (int i = 0; i < 3; i++) tick(440, 362, 0);
        tick(440, 362, 2);
        for (int k = 1; k <= 442; k++) tick(px(k), py(k), 2);

        // Button in AUTO takes over the same tick; release returns to IDLE.
        btn_y_n = 1'b0; dir_y = 1'b0;
        tick(878, 643, 1);
        btn_y_n = 1'b1;
        tick(878, 643, 0);
        for (int i = 0; i < 3; i++) tick(878, 643, 0);
        tick(878, 643, 2);
        tick(877, 642, 2);
        auto_en = 1'b0;
        tick(877, 642, 0);

        // Both axes in one tick.
        btn_x_n = 1'b0; btn_y_n = 1'b0; dir_x = 1'b0; dir_y = 1'b1;
        tick(876, 643, 1);
        btn_x_n = 1'b1; btn_y_n = 1'b1;
        tick(876, 643, 0);

        // Back into AUTO, then reset asynchronously while VS is high.
        auto_en = 1'b1;
        for (int i = 0; i < 3; i++) tick(876, 643, 0);
        tick(876, 643, 2);
        @(negedge VGA_CLK) VGA_VS = 1'b1;
        @(posedge VGA_CLK);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_posx", int'(posx), 440);
        chk("async_rst_posy", int'(posy), 362);
        chk("async_rst_mode", int'(mode), 0);
        chk("async_rst_frame_tick", int'(frame_tick), 0);
        auto_en = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge VGA_CLK) chk("rst_hold_frame_tick", int'(frame_tick), 0);
        reset = 1'b0;
        // VS still high at release: no tick allowed until it goes low and high again.
        for (int i = 0; i < 6; i++) @(negedge VGA_CLK) chk("vs_high_release_no_tick", int'(frame_tick), 0);
        VGA_VS = 1'b0;
        repeat (4) @(negedge VGA_CLK);
        tick(440, 362, 0);

        repeat (4) @(negedge VGA_CLK);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
